// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: shift-add multiplier and restoring divider
// iterated over D_WIDTH cycles, stalling the pipeline until the result is presented.
module muldiv_ctrl #(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] op_a,
  input  logic [D_WIDTH-1:0] op_b,
  input  logic               flush,
  output logic               stall,
  output logic               done,
  output logic [D_WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(D_WIDTH);
  localparam int unsigned P_W   = 2 * D_WIDTH;
  localparam logic [D_WIDTH-1:0] MIN_INT = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [D_WIDTH-1:0] acc_q, acc_d;
  logic [D_WIDTH-1:0] lo_q, lo_d;
  logic [D_WIDTH-1:0] opnd_q, opnd_d;
  logic               done_q, done_d;
  logic [D_WIDTH-1:0] result_q, result_d;

  // Operand decode at acceptance: sign flags, magnitudes and early-out divides
  logic               in_div, in_neg_a, in_neg_b, in_div_zero, in_div_ovf;
  logic [D_WIDTH-1:0] in_mag_a, in_mag_b, in_special;

  always_comb begin
    in_div      = funct3[2];
    in_neg_a    = (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6}) && op_a[D_WIDTH-1];
    in_neg_b    = (funct3 inside {3'd1, 3'd4, 3'd6}) && op_b[D_WIDTH-1];
    in_mag_a    = in_neg_a ? -op_a : op_a;
    in_mag_b    = in_neg_b ? -op_b : op_b;
    in_div_zero = (op_b == '0);
    in_div_ovf  = !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
    in_special  = '0;
    if (in_div_zero) begin
      in_special = funct3[1] ? op_a : '1;
    end else if (in_div_ovf) begin
      in_special = funct3[1] ? '0 : MIN_INT;
    end
  end

  // One iteration of the selected algorithm plus sign fix-up of its outcome
  logic [D_WIDTH:0]   mul_sum, div_rem_sh, div_diff;
  logic [D_WIDTH-1:0] acc_it, lo_it, quo_fix, rem_fix, final_res;
  logic [P_W-1:0]     prod, prod_fix;

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rem_sh = {acc_q, lo_q[D_WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, opnd_q};
    if (f3_q[2]) begin
      acc_it = div_diff[D_WIDTH] ? div_rem_sh[D_WIDTH-1:0] : div_diff[D_WIDTH-1:0];
      lo_it  = {lo_q[D_WIDTH-2:0], ~div_diff[D_WIDTH]};
    end else begin
      acc_it = mul_sum[D_WIDTH:1];
      lo_it  = {mul_sum[0], lo_q[D_WIDTH-1:1]};
    end
    prod     = {acc_it, lo_it};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quo_fix  = (sa_q ^ sb_q) ? -lo_it : lo_it;
    rem_fix  = sa_q ? -acc_it : acc_it;
    if (f3_q[2]) begin
      final_res = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      final_res = (f3_q[1:0] == 2'd0) ? prod_fix[D_WIDTH-1:0] : prod_fix[P_W-1:D_WIDTH];
    end
  end

  assign stall  = rst_n & (((state_q == ST_IDLE) & req & ~flush) | (state_q == ST_BUSY));
  assign done   = done_q;
  assign result = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    done_d   = 1'b0;
    result_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req && !flush) begin
          f3_d   = funct3;
          sa_d   = in_neg_a;
          sb_d   = in_neg_b;
          acc_d  = '0;
          opnd_d = in_div ? in_mag_b : in_mag_a;
          lo_d   = in_div ? in_mag_a : in_mag_b;
          if (in_div && (in_div_zero || in_div_ovf)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = in_special;
          end else begin
            cnt_d   = CNT_W'(D_WIDTH - 1);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_it;
          lo_d  = lo_it;
          if (cnt_q == '0) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = final_res;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner ops, flush/reset interruption and
// random ops, each cycle compared against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_vec;
  int n_err;
  int cyc_cnt;
  int done_at;

  muldiv_ctrl #(.D_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({stall, done, result});
  endfunction

  // Reference: RV32M semantics in 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MIN_INT && b == 32'hFFFF_FFFF) r = MIN_INT;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN_INT && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3 >= 3'd4 && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) &&
                                  a == MIN_INT && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return MIN_INT;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Present one op and check stall/done/result every cycle up to the done cycle;
  // req stays asserted through the done cycle like the pipeline would.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [31:0] expv;
    expv = ref_result(f3, a, b);
    lat  = ref_latency(f3, a, b);
    @(negedge clk);
    req    = 1'b1;
    flush  = 1'b0;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    #1 check_eq($sformatf("accept f3=%0d a=%h b=%h", f3, a, b), outs(), 64'({2'b10, 32'h0}));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1 check_eq($sformatf("f3=%0d a=%h b=%h cyc=%0d", f3, a, b, k), outs(),
                  (k == lat) ? 64'({2'b01, expv}) : 64'({2'b10, 32'h0}));
    end
    done_at = cyc_cnt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req   = 1'b0;
      flush = 1'b0;
      #1 check_eq("idle", outs(), 64'h0);
    end
  endtask

  // Start a MUL and flush it at BUSY cycle k; it must vanish without a done pulse.
  task automatic flush_at(input int k);
    @(negedge clk);
    req    = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd123;
    op_b   = 32'd456;
    for (int i = 1; i <= k; i++) @(negedge clk);
    #1 check_eq($sformatf("busy before flush k=%0d", k), outs(), 64'({2'b10, 32'h0}));
    flush = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1 check_eq($sformatf("after flush k=%0d", k), outs(), 64'h0);
    idle(3);
  endtask

  initial begin
    int t_first;
    n_vec   = 0;
    n_err   = 0;
    cyc_cnt = 0;
    rst_n   = 1'b0;
    req     = 1'b1;
    flush   = 1'b0;
    funct3  = 3'd0;
    op_a    = 32'd5;
    op_b    = 32'd6;
    repeat (2) @(negedge clk);
    #1 check_eq("reset outputs", outs(), 64'h0);
    req   = 1'b0;
    rst_n = 1'b1;
    idle(2);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    idle(1);
    run_op(3'd1, MIN_INT, MIN_INT);
    run_op(3'd3, MIN_INT, MIN_INT);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    idle(1);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7);
    idle(1);
    run_op(3'd4, 32'd100, 32'd0);
    run_op(3'd6, 32'd100, 32'd0);
    run_op(3'd4, MIN_INT, 32'hFFFF_FFFF);
    run_op(3'd6, MIN_INT, 32'hFFFF_FFFF);
    run_op(3'd5, MIN_INT, 32'hFFFF_FFFF);
    idle(1);

    run_op(3'd0, 32'd11, 32'd13);
    t_first = done_at;
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    check_eq("done spacing", 64'(done_at - t_first), 64'd34);
    idle(1);

    @(negedge clk);
    req    = 1'b1;
    flush  = 1'b1;
    funct3 = 3'd0;
    #1 check_eq("flush in idle", outs(), 64'h0);
    idle(3);

    flush_at(10);
    run_op(3'd0, 32'd9, 32'd9);
    idle(1);
    flush_at(32);
    idle(1);

    @(negedge clk);
    req    = 1'b1;
    funct3 = 3'd5;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("reset mid-op", outs(), 64'h0);
    @(negedge clk);
    req = 1'b0;
    #1 check_eq("held in reset", outs(), 64'h0);
    rst_n = 1'b1;
    idle(3);
    run_op(3'd7, 32'd1000, 32'd3);

    for (int n = 0; n < 40; n++) begin
      int gap;
      run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
